// File: rtl/bmp180_instr_seq.sv
// BMP180 command sequencer: fetches an opcode from ROM and expands it into I2C write / conversion wait / read steps.
// Latency: opcode is decoded 3 cycles after command accept; one I2C transaction is in flight at a time, and commands are not accepted while busy.
module bmp180_instr_seq #(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 8,
    parameter int CLK_MHZ     = 50
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   I_CMD_VLD,
    input  logic [ADDR_ROM_SZ-1:0] I_CMD_ADDR,
    output logic                   O_CMD_RDY,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
    input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM,
    output logic                   O_I2C_START,
    output logic                   O_I2C_RW,
    output logic [7:0]             O_I2C_REG,
    output logic [7:0]             O_I2C_WDATA,
    output logic [4:0]             O_I2C_NBYTES,
    input  logic                   I_I2C_DONE,
    input  logic                   I_I2C_NACK,
    input  logic                   I_I2C_RX_VLD,
    input  logic [7:0]             I_I2C_RX_DATA,
    output logic                   O_RD_VLD,
    output logic [7:0]             O_RD_DATA,
    output logic [4:0]             O_RD_IDX,
    output logic                   O_DONE,
    output logic                   O_ERR
);
    typedef enum logic [3:0] {
        IDLE, FETCH, ROMWAIT, DECODE, I2C_WR, WAIT_WR, CONV, I2C_RD, WAIT_RD, FIN
    } state_t;

    localparam int CONV_W = 21;

    function automatic logic is_meas(input logic [7:0] op);
        return (op == 8'h2E) || (op == 8'h34) || (op == 8'h74) || (op == 8'hB4) || (op == 8'hF4);
    endfunction

    function automatic logic [14:0] wait_us(input logic [7:0] op);
        case (op)
            8'h2E, 8'h34: return 15'd4500;
            8'h74:        return 15'd7500;
            8'hB4:        return 15'd13500;
            8'hF4:        return 15'd25500;
            default:      return 15'd0;
        endcase
    endfunction

    function automatic logic [4:0] rd_nbytes(input logic [7:0] op);
        case (op)
            8'hAA:   return 5'd22;
            8'hD0:   return 5'd1;
            8'h2E:   return 5'd2;
            default: return 5'd3;
        endcase
    endfunction

    // Counter runs load..0 inclusive, so CONV lasts exactly wait_us*CLK_MHZ cycles.
    function automatic logic [CONV_W-1:0] conv_load(input logic [7:0] op);
        return CONV_W'(int'(wait_us(op)) * CLK_MHZ - 1);
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_ROM_SZ-1:0] addr_q, addr_d;
    logic [DATA_ROM_SZ-1:0] op_q, op_d;
    logic                   rw_q, rw_d;
    logic [7:0]             reg_q, reg_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [4:0]             nbytes_q, nbytes_d;
    logic [CONV_W-1:0]      conv_q, conv_d;
    logic [4:0]             rx_cnt_q, rx_cnt_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic [4:0]             rd_idx_q, rd_idx_d;
    logic                   err_q, err_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            rw_q      <= 1'b0;
            reg_q     <= '0;
            wdata_q   <= '0;
            nbytes_q  <= '0;
            conv_q    <= '0;
            rx_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            rw_q      <= rw_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            nbytes_q  <= nbytes_d;
            conv_q    <= conv_d;
            rx_cnt_q  <= rx_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        rw_d      = rw_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        nbytes_d  = nbytes_q;
        conv_d    = conv_q;
        rx_cnt_d  = rx_cnt_q;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        rd_idx_d  = rd_idx_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_CMD_VLD) begin
                    addr_d  = I_CMD_ADDR;
                    state_d = FETCH;
                end
            end
            FETCH:   state_d = ROMWAIT;
            ROMWAIT: state_d = DECODE;
            DECODE: begin
                op_d = I_DATA_ROM;
                if (I_ADDR_ROM != addr_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (I_DATA_ROM[7:0] == 8'hAA || I_DATA_ROM[7:0] == 8'hD0) begin
                    rw_d     = 1'b1;
                    reg_d    = I_DATA_ROM[7:0];
                    nbytes_d = rd_nbytes(I_DATA_ROM[7:0]);
                    state_d  = I2C_RD;
                end else if (I_DATA_ROM[7:0] == 8'hB6 || is_meas(I_DATA_ROM[7:0])) begin
                    rw_d     = 1'b0;
                    reg_d    = (I_DATA_ROM[7:0] == 8'hB6) ? 8'hE0 : 8'hF4;
                    wdata_d  = I_DATA_ROM[7:0];
                    nbytes_d = 5'd0;
                    state_d  = I2C_WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            I2C_WR: state_d = WAIT_WR;
            WAIT_WR: begin
                if (I_I2C_DONE) begin
                    if (I_I2C_NACK) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (is_meas(op_q[7:0])) begin
                        conv_d   = conv_load(op_q[7:0]);
                        rw_d     = 1'b1;
                        reg_d    = 8'hF6;
                        nbytes_d = rd_nbytes(op_q[7:0]);
                        state_d  = CONV;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            CONV: begin
                if (conv_q == '0) state_d = I2C_RD;
                else              conv_d  = conv_q - 1'b1;
            end
            I2C_RD: begin
                rx_cnt_d = '0;
                state_d  = WAIT_RD;
            end
            WAIT_RD: begin
                // A byte arriving with DONE is still forwarded; surplus bytes are dropped.
                if (I_I2C_RX_VLD && (rx_cnt_q < nbytes_q)) begin
                    rd_vld_d  = 1'b1;
                    rd_data_d = I_I2C_RX_DATA;
                    rd_idx_d  = rx_cnt_q;
                    rx_cnt_d  = rx_cnt_q + 1'b1;
                end
                if (I_I2C_DONE) begin
                    err_d   = I_I2C_NACK;
                    state_d = I_I2C_NACK ? IDLE : FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        O_CMD_RDY    = (state_q == IDLE);
        O_I2C_START  = (state_q == I2C_WR) || (state_q == I2C_RD);
        O_DONE       = (state_q == FIN);
        O_ADDR_ROM   = addr_q;
        O_I2C_RW     = rw_q;
        O_I2C_REG    = reg_q;
        O_I2C_WDATA  = wdata_q;
        O_I2C_NBYTES = nbytes_q;
        O_RD_VLD     = rd_vld_q;
        O_RD_DATA    = rd_data_q;
        O_RD_IDX     = rd_idx_q;
        O_ERR        = err_q;
    end
endmodule

// File: tb/tb_bmp180_instr_seq.sv
// Randomized bench for bmp180_instr_seq: ROM and I2C slave models plus an opcode-table reference model.
module tb_bmp180_instr_seq;
    localparam int MHZ = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       I_CMD_VLD = 1'b0;
    logic [3:0] I_CMD_ADDR = '0;
    logic       O_CMD_RDY;
    logic [3:0] O_ADDR_ROM;
    logic [3:0] I_ADDR_ROM = '0;
    logic [7:0] I_DATA_ROM = '0;
    logic       O_I2C_START, O_I2C_RW;
    logic [7:0] O_I2C_REG, O_I2C_WDATA;
    logic [4:0] O_I2C_NBYTES;
    logic       I_I2C_DONE = 1'b0, I_I2C_NACK = 1'b0, I_I2C_RX_VLD = 1'b0;
    logic [7:0] I_I2C_RX_DATA = '0;
    logic       O_RD_VLD;
    logic [7:0] O_RD_DATA;
    logic [4:0] O_RD_IDX;
    logic       O_DONE, O_ERR;

    bmp180_instr_seq #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(8), .CLK_MHZ(MHZ)) dut (
        .CLK(CLK), .RST(RST), .I_CMD_VLD(I_CMD_VLD), .I_CMD_ADDR(I_CMD_ADDR), .O_CMD_RDY(O_CMD_RDY),
        .O_ADDR_ROM(O_ADDR_ROM), .I_ADDR_ROM(I_ADDR_ROM), .I_DATA_ROM(I_DATA_ROM),
        .O_I2C_START(O_I2C_START), .O_I2C_RW(O_I2C_RW), .O_I2C_REG(O_I2C_REG),
        .O_I2C_WDATA(O_I2C_WDATA), .O_I2C_NBYTES(O_I2C_NBYTES), .I_I2C_DONE(I_I2C_DONE),
        .I_I2C_NACK(I_I2C_NACK), .I_I2C_RX_VLD(I_I2C_RX_VLD), .I_I2C_RX_DATA(I_I2C_RX_DATA),
        .O_RD_VLD(O_RD_VLD), .O_RD_DATA(O_RD_DATA), .O_RD_IDX(O_RD_IDX), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [43:0] outs;
    assign outs = {O_CMD_RDY, O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG, O_I2C_WDATA,
                   O_I2C_NBYTES, O_RD_VLD, O_RD_DATA, O_RD_IDX, O_DONE, O_ERR};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered ROM with address echo; echo_mask corrupts the echo on demand.
    logic [7:0] rom [16];
    logic [3:0] echo_mask = '0;
    always @(posedge CLK) begin
        I_ADDR_ROM <= O_ADDR_ROM ^ echo_mask;
        I_DATA_ROM <= rom[O_ADDR_ROM];
    end

    typedef struct {logic [7:0] d; int idx;} rx_t;
    rx_t rx_exp[$];
    int  st_rw[$], st_reg[$], st_wd[$], st_nb[$], st_cyc[$];
    int  wr_done_cyc = 0;
    bit  wr_done_seen = 0;
    bit  nack_wr = 0;
    int  n_fwd = 0;

    // I2C slave model: answers each START, sends a few surplus bytes on reads.
    initial begin : i2c_slave
        logic       rw;
        logic [7:0] rg, wd;
        int         nb, d, tot;
        rx_t        r;
        forever begin
            @(negedge CLK);
            if (O_I2C_START === 1'b1) begin
                rw = O_I2C_RW; rg = O_I2C_REG; wd = O_I2C_WDATA; nb = int'(O_I2C_NBYTES);
                st_rw.push_back(int'(rw)); st_reg.push_back(int'(rg));
                st_wd.push_back(int'(wd)); st_nb.push_back(nb); st_cyc.push_back(cyc);
                if (!rw) begin
                    d = 2 + $urandom_range(0, 3);
                    @(negedge CLK);
                    I_I2C_RX_VLD = 1'b1; I_I2C_RX_DATA = 8'($urandom);
                    @(negedge CLK);
                    I_I2C_RX_VLD = 1'b0;
                    repeat (d - 2) @(negedge CLK);
                    chk("wr_hold", {O_I2C_RW, O_I2C_REG, O_I2C_WDATA}, {rw, rg, wd});
                    I_I2C_DONE = 1'b1; I_I2C_NACK = nack_wr;
                    wr_done_cyc = cyc; wr_done_seen = 1;
                    @(negedge CLK);
                    I_I2C_DONE = 1'b0; I_I2C_NACK = 1'b0;
                end else begin
                    tot = nb + $urandom_range(0, 2);
                    @(negedge CLK);
                    for (int k = 0; k < tot; k++) begin
                        repeat ($urandom_range(0, 1)) @(negedge CLK);
                        I_I2C_RX_VLD = 1'b1; I_I2C_RX_DATA = 8'($urandom);
                        if (k < nb) begin
                            r.d = I_I2C_RX_DATA; r.idx = k;
                            rx_exp.push_back(r);
                        end
                        if (k == tot - 1) begin
                            chk("rd_hold", {O_I2C_RW, O_I2C_REG, O_I2C_NBYTES}, {rw, rg, 5'(nb)});
                            I_I2C_DONE = 1'b1;
                        end
                        @(negedge CLK);
                        I_I2C_RX_VLD = 1'b0; I_I2C_DONE = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : rd_monitor
        rx_t e;
        forever begin
            @(negedge CLK);
            if (O_RD_VLD === 1'b1) begin
                n_fwd++;
                if (rx_exp.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = rx_exp.pop_front();
                    chk("rd_data", O_RD_DATA, e.d);
                    chk("rd_idx", O_RD_IDX, e.idx);
                end
            end
        end
    end

    task automatic clear_logs();
        st_rw.delete(); st_reg.delete(); st_wd.delete(); st_nb.delete(); st_cyc.delete();
        rx_exp.delete(); n_fwd = 0; wr_done_seen = 0;
    endtask

    task automatic issue(input logic [3:0] a, output int acc);
        @(negedge CLK);
        chk("cmd_rdy", O_CMD_RDY, 1);
        I_CMD_VLD = 1'b1; I_CMD_ADDR = a;
        @(negedge CLK);
        I_CMD_VLD = 1'b0; acc = cyc;
        chk("rom_addr", O_ADDR_ROM, a);
    endtask

    task automatic wait_end(input bit poke, output bit got_done, output bit got_err, output int end_cyc);
        got_done = 0; got_err = 0; end_cyc = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge CLK);
            I_CMD_VLD = (poke && i == 1);
            I_CMD_ADDR = (poke && i == 1) ? 4'hF : I_CMD_ADDR;
            if (O_DONE === 1'b1) begin got_done = 1; end_cyc = cyc; break; end
            if (O_ERR === 1'b1)  begin got_err = 1;  end_cyc = cyc; break; end
        end
        I_CMD_VLD = 1'b0;
        if (!got_done && !got_err) chk("cmd_timeout", 1, 0);
    endtask

    // Reference: what the BMP180 opcode table says each command must do.
    task automatic run(input logic [3:0] a, input logic [7:0] op, input bit bad, input bit nack, input bit poke);
        bit         exp_err, dec_err, has_wr, has_rd, gd, ge;
        logic [7:0] wreg, rreg;
        int         nb, wus, acc, ec, j;
        exp_err = 0; has_wr = 0; has_rd = 0; wreg = 0; rreg = 0; nb = 0; wus = 0;
        case (op)
            8'hAA: begin has_rd = 1; rreg = 8'hAA; nb = 22; end
            8'hD0: begin has_rd = 1; rreg = 8'hD0; nb = 1; end
            8'hB6: begin has_wr = 1; wreg = 8'hE0; end
            8'h2E: begin has_wr = 1; wreg = 8'hF4; wus = 4500;  has_rd = 1; rreg = 8'hF6; nb = 2; end
            8'h34: begin has_wr = 1; wreg = 8'hF4; wus = 4500;  has_rd = 1; rreg = 8'hF6; nb = 3; end
            8'h74: begin has_wr = 1; wreg = 8'hF4; wus = 7500;  has_rd = 1; rreg = 8'hF6; nb = 3; end
            8'hB4: begin has_wr = 1; wreg = 8'hF4; wus = 13500; has_rd = 1; rreg = 8'hF6; nb = 3; end
            8'hF4: begin has_wr = 1; wreg = 8'hF4; wus = 25500; has_rd = 1; rreg = 8'hF6; nb = 3; end
            default: exp_err = 1;
        endcase
        if (bad) begin exp_err = 1; has_wr = 0; has_rd = 0; end
        dec_err = exp_err;
        if (nack && has_wr) begin exp_err = 1; has_rd = 0; end

        rom[a] = op; echo_mask = bad ? 4'h1 : 4'h0; nack_wr = nack;
        clear_logs();
        issue(a, acc);
        wait_end(poke, gd, ge, ec);
        chk($sformatf("done_%0h", op), gd, !exp_err);
        chk($sformatf("err_%0h", op), ge, exp_err);
        if (dec_err) chk("err_latency", ec - acc, 3);
        @(negedge CLK);
        chk("rdy_after", O_CMD_RDY, 1);
        repeat (4) @(negedge CLK);
        chk("n_start", st_rw.size(), int'(has_wr) + int'(has_rd));
        j = 0;
        if (has_wr && st_rw.size() > 0) begin
            chk("wr_rw", st_rw[0], 0);
            chk("wr_reg", st_reg[0], wreg);
            chk("wr_data", st_wd[0], op);
            chk("wr_start_lat", st_cyc[0] - acc, 3);
            j = 1;
        end
        if (has_rd && st_rw.size() > j) begin
            chk("rd_rw", st_rw[j], 1);
            chk("rd_reg", st_reg[j], rreg);
            chk("rd_nbytes", st_nb[j], nb);
            if (has_wr) chk("conv_cycles", st_cyc[j] - wr_done_cyc - 1, wus * MHZ);
            else        chk("rd_start_lat", st_cyc[j] - acc, 3);
        end
        chk("n_fwd", n_fwd, has_rd ? nb : 0);
        chk("rx_left", rx_exp.size(), 0);
        if (poke) chk("busy_addr_hold", O_ADDR_ROM, a);
        echo_mask = '0; nack_wr = 0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  acc;
        bit  quiet;
        logic [7:0] op;
        foreach (rom[i]) rom[i] = 8'h00;
        repeat (3) @(negedge CLK);
        chk("reset_outs", outs, {1'b1, 43'b0});
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run(4'h0, 8'hD0, 0, 0, 1);
        run(4'h1, 8'h2E, 0, 0, 0);
        run(4'h2, 8'hF4, 0, 0, 0);
        run(4'h3, 8'hAA, 0, 0, 1);
        run(4'h4, 8'h5A, 0, 0, 0);
        run(4'h6, 8'hD0, 1, 0, 0);
        run(4'h7, 8'h34, 0, 1, 0);
        run(4'h8, 8'hB6, 0, 0, 0);
        run(4'h9, 8'h74, 0, 0, 0);

        // Reset in the middle of a conversion wait.
        rom[4'h5] = 8'h2E;
        clear_logs();
        issue(4'h5, acc);
        for (int i = 0; i < 200 && !wr_done_seen; i++) @(negedge CLK);
        chk("rst_wr_seen", wr_done_seen, 1);
        repeat (100) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_outs", outs, {1'b1, 43'b0});
        quiet = 1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (O_DONE !== 1'b0 || O_ERR !== 1'b0 || O_I2C_START !== 1'b0 || O_CMD_RDY !== 1'b1) quiet = 0;
        end
        chk("rst_quiet", quiet, 1);
        run(4'h0, 8'hD0, 0, 0, 1);

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 3))
                0: op = 8'hAA;
                1: op = 8'hD0;
                2: op = 8'hB6;
                default: op = 8'($urandom);
            endcase
            run(4'($urandom_range(0, 15)), op, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
